philv_vector_checker: RTL

Synthesizable, self-checking test-vector engine for on-FPGA regression of `philosophy_v_core` and its sub-units. It holds a loadable table of `{instr, a, b, c_expected}` vectors and drives them into the DUT back-to-back, one per clock. It compares each DUT result after a configurable pipeline latency and reports the error count, the index of the first failing vector, and completion. It replaces the simulation-only bench flow for hardware bring-up and supports pipelined (multi-cycle) cores, which the single-cycle bench cannot check.

---
 rtl/philv_vector_checker.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/philv_vector_checker.sv
`default_nettype none
// ============================================================================
// Module      : philv_vector_checker
// Description : On-FPGA test-vector engine. Holds a loadable table of
//               {instr, a, b, c_expected} vectors, drives them into a DUT one
//               per clock and compares each result after LATENCY cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module philv_vector_checker #(
   parameter int N           = 32,
   parameter int INSTR_WIDTH = 32,
   parameter int DEPTH       = 16,
   parameter int LATENCY     = 1,
   parameter int ERR_W       = 16,
   localparam int AW         = $clog2(DEPTH),
   localparam int TV_WIDTH   = INSTR_WIDTH + 3*N
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_en,
   input  logic [AW-1:0]          load_addr,
   input  logic [TV_WIDTH-1:0]    load_data,
   input  logic [AW:0]            num_vectors,
   input  logic                   start,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [N-1:0]           a,
   output logic [N-1:0]           b,
   input  logic [N-1:0]           dut_c,
   output logic                   busy,
   output logic                   done,
   output logic                   mismatch,
   output logic [ERR_W-1:0]       errors,
   output logic                   first_err_valid,
   output logic [AW-1:0]          first_err_idx
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_next;

   logic [TV_WIDTH-1:0] table_mem [DEPTH];
   logic [AW:0]         n_r;        // vectors in the current run
   logic [AW-1:0]       cnt;        // index of the vector currently driven
   logic                load_ok;
   logic                issue_en;
   logic [AW-1:0]       issue_idx;
   logic                run_start;
   logic                pending;
   logic                fail;
   logic [TV_WIDTH-1:0] rd_vec;

   // Stage 0 is aligned with the registered stimulus; stage LATENCY is
   // aligned with the DUT result being sampled.
   logic [LATENCY:0]    pipe_vld;
   logic [AW-1:0]       pipe_idx [LATENCY+1];
   logic [N-1:0]        pipe_cx  [LATENCY+1];

   assign load_ok = load_en && ((state == IDLE) || (state == DONE));
   assign busy    = (state == RUN) || (state == DRAIN);
   assign done    = (state == DONE);

   // A write in the start cycle is forwarded so the run sees the new entry.
   assign rd_vec  = (load_ok && (load_addr == issue_idx)) ? load_data : table_mem[issue_idx];
   assign fail    = pipe_vld[LATENCY] && (dut_c != pipe_cx[LATENCY]);

   // Vector table write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (load_ok) begin
         table_mem[load_addr] <= load_data;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and per-cycle issue decision.
   always_comb begin
      state_next = state;
      issue_en   = 1'b0;
      issue_idx  = '0;
      run_start  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               run_start = 1'b1;
               if (num_vectors == '0) begin
                  state_next = DONE;
               end else begin
                  state_next = RUN;
                  issue_en   = 1'b1;
               end
            end
         end
         RUN: begin
            if ({1'b0, cnt} == (n_r - (AW+1)'(1))) begin
               state_next = (LATENCY == 0) ? DONE : DRAIN;
            end else begin
               issue_en  = 1'b1;
               issue_idx = cnt + AW'(1);
            end
         end
         DRAIN: begin
            if (!pending) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Any vector still in flight ahead of the compare stage keeps DRAIN alive.
   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
         pending = pending | pipe_vld[i];
      end
   end

   // Registered stimulus outputs, zero whenever no vector is being issued.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr <= '0;
         a     <= '0;
         b     <= '0;
         cnt   <= '0;
         n_r   <= '0;
      end else begin
         if (run_start) begin
            n_r <= num_vectors;
         end
         if (issue_en) begin
            instr <= rd_vec[TV_WIDTH-1 -: INSTR_WIDTH];
            a     <= rd_vec[3*N-1 -: N];
            b     <= rd_vec[2*N-1 -: N];
            cnt   <= issue_idx;
         end else begin
            instr <= '0;
            a     <= '0;
            b     <= '0;
         end
      end
   end

   // Expected-result delay line; only the valid bits need flushing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pipe_vld <= '0;
      end else begin
         pipe_vld[0] <= issue_en;
         for (int i = 1; i <= LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
         end
      end
      pipe_idx[0] <= issue_idx;
      pipe_cx[0]  <= rd_vec[N-1:0];
      for (int i = 1; i <= LATENCY; i++) begin
         pipe_idx[i] <= pipe_idx[i-1];
         pipe_cx[i]  <= pipe_cx[i-1];
      end
   end

   // Compare result bookkeeping: mismatch pulse, saturating count, first index.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mismatch        <= 1'b0;
         errors          <= '0;
         first_err_valid <= 1'b0;
         first_err_idx   <= '0;
      end else begin
         mismatch <= fail;
         if (run_start) begin
            errors          <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
         end else if (fail) begin
            if (errors != '1) begin
               errors <= errors + ERR_W'(1);
            end
            if (!first_err_valid) begin
               first_err_valid <= 1'b1;
               first_err_idx   <= pipe_idx[LATENCY];
            end
         end
      end
   end

endmodule
`default_nettype wire
